// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared widths and state encoding for the two-master bus arbiter
package bus_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int WAIT_W = 16;
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} arb_state_t;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: per-transfer wait counter that flags when the slave has stalled TIMEOUT cycles
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    logic [WAIT_W-1:0] wait_cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) wait_cnt <= '0;
        else if (clear) wait_cnt <= '0;
        else if (count) wait_cnt <= wait_cnt + 1'b1;
    assign expired = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master to one-slave arbiter with transfer-long grant and watchdog
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             m_valid,
    input  logic [1:0][ADDR_W-1:0] m_address,
    input  logic [1:0][STRB_W-1:0] m_wstrobe,
    input  logic [1:0][DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]      m_rdata,
    output logic [1:0]             m_ready,
    output logic                   m_irq,
    output logic                   s_valid,
    output logic [ADDR_W-1:0]      s_address,
    output logic [STRB_W-1:0]      s_wstrobe,
    output logic [DATA_W-1:0]      s_wdata,
    input  logic [DATA_W-1:0]      s_rdata,
    input  logic                   s_ready,
    input  logic                   s_irq,
    output logic                   timeout_pulse
);
    arb_state_t state, state_nx;
    logic last, owner, busy, expired, timeout, done, grant;
    assign busy    = state != IDLE;
    assign owner   = state == BUSY1;
    assign timeout = busy && expired && !s_ready;
    assign done    = busy && (s_ready || timeout);
    assign grant   = (state_nx != IDLE) && (!busy || done);
    assign timeout_pulse = timeout;
    assign m_irq     = s_irq;
    assign s_valid   = busy && m_valid[owner] && !timeout;
    assign s_address = busy ? m_address[owner] : '0;
    assign s_wstrobe = busy ? m_wstrobe[owner] : '0;
    assign s_wdata   = busy ? m_wdata[owner] : '0;
    assign m_rdata   = (busy && !timeout) ? s_rdata : '0;
    assign m_ready   = done ? (owner ? 2'b10 : 2'b01) : 2'b00;
    // the finishing master still holds valid this cycle, so only the other one can take over
    always_comb begin
        state_nx = state;
        if (!busy)
            state_nx = (m_valid == 2'b11) ? (last ? BUSY0 : BUSY1) :
                       m_valid[0] ? BUSY0 : m_valid[1] ? BUSY1 : IDLE;
        else if (done)
            state_nx = m_valid[~owner] ? (owner ? BUSY0 : BUSY1) : IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            if (done) last <= owner;
        end
    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant),
        .count  (busy && !s_ready),
        .expired(expired)
    );
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic against an ownership-level reference model
module tb_bus_arbiter;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] m_valid = '0;
    logic [1:0][31:0] m_address = '0;
    logic [1:0][3:0] m_wstrobe = '0;
    logic [1:0][31:0] m_wdata = '0;
    logic [31:0] m_rdata;
    logic [1:0] m_ready;
    logic m_irq, s_valid, timeout_pulse;
    logic [31:0] s_address, s_wdata;
    logic [3:0] s_wstrobe;
    logic [31:0] s_rdata = '0;
    logic s_ready = 1'b0;
    logic s_irq = 1'b0;
    int errors = 0;
    int checks = 0;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_address(m_address),
        .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
        .m_irq(m_irq), .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready), .s_irq(s_irq),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        m_valid = '0;
        s_ready = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        m_valid = 2'b11;
        s_ready = 1'b1;
        s_rdata = 32'hFFFF_FFFF;
        m_address = {32'h1111_1111, 32'h2222_2222};
        #2;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset s_valid got=%b exp=0", s_valid); end
        checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL reset m_ready got=%b exp=00", m_ready); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset timeout_pulse got=%b exp=0", timeout_pulse); end
        checks++; if ({s_address, s_wdata, s_wstrobe} !== '0) begin errors++; $display("FAIL reset s_bus got=%h/%h/%h exp=0", s_address, s_wdata, s_wstrobe); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset m_rdata got=%h exp=0", m_rdata); end
        tick();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_held s_valid got=%b exp=0", s_valid); end
        reset = 1'b0;
        m_valid = '0;
        s_ready = 1'b0;
        tick();
    endtask

    task automatic test_single;
        m_valid = 2'b01;
        m_address[0] = 32'h0000_0040;
        m_wstrobe[0] = 4'h0;
        s_rdata = 32'hDEAD_BEEF;
        #2;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single latency s_valid got=%b exp=0", s_valid); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            s_ready = (c == 3);
            #2;
            checks++; if (s_valid !== 1'b1 || s_address !== 32'h40) begin errors++; $display("FAIL single c%0d s_valid/addr got=%b/%h exp=1/00000040", c, s_valid, s_address); end
            checks++; if (m_ready !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single c%0d m_ready got=%b exp=%b", c, m_ready, (c == 3) ? 2'b01 : 2'b00); end
            if (c == 3) begin
                checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single m_rdata got=%h exp=deadbeef", m_rdata); end
            end
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        #2;
        checks++; if (s_valid !== 1'b0 || s_address !== 32'h0) begin errors++; $display("FAIL single idle s_valid/addr got=%b/%h exp=0/0", s_valid, s_address); end
        tick();
    endtask

    task automatic test_contention;
        do_reset();
        m_valid = 2'b11;
        m_address = {32'h0000_0200, 32'h0000_0100};
        s_ready = 1'b1;
        #2;
        checks++; if (s_valid !== 1'b0 || m_ready !== 2'b00) begin errors++; $display("FAIL contend idle s_valid/m_ready got=%b/%b exp=0/00", s_valid, m_ready); end
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) m_valid = 2'b10;
            #2;
            checks++; if (m_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contend k%0d m_ready got=%b exp=%b", k, m_ready, (k % 2) ? 2'b10 : 2'b01); end
            checks++; if (s_address !== ((k % 2) ? 32'h200 : 32'h100)) begin errors++; $display("FAIL contend k%0d s_address got=%h exp=%h", k, s_address, (k % 2) ? 32'h200 : 32'h100); end
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        #2;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL contend end s_valid got=%b exp=0", s_valid); end
        tick();
    endtask

    task automatic test_write;
        m_valid = 2'b10;
        m_address = {32'h0000_0080, 32'h0000_BAD0};
        m_wdata = {32'h1234_5678, 32'hAAAA_AAAA};
        m_wstrobe = {4'b0011, 4'b1111};
        tick();
        for (int k = 0; k < 3; k++) begin
            s_ready = (k == 2);
            #2;
            checks++; if (s_wstrobe !== 4'b0011 || s_wdata !== 32'h1234_5678 || s_address !== 32'h80) begin errors++; $display("FAIL write k%0d fwd got=%b/%h/%h exp=0011/12345678/00000080", k, s_wstrobe, s_wdata, s_address); end
            checks++; if (m_ready !== ((k == 2) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL write k%0d m_ready got=%b exp=%b", k, m_ready, (k == 2) ? 2'b10 : 2'b00); end
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        m_wstrobe = '0;
        tick();
    endtask

    task automatic test_watchdog;
        m_valid = 2'b01;
        m_address = {32'h0000_0300, 32'h0000_0040};
        s_rdata = 32'h5555_AAAA;
        tick();
        for (int c = 1; c <= TO + 1; c++) begin
            if (c == 2) m_valid = 2'b11;
            #2;
            if (c <= TO) begin
                checks++; if (m_ready !== 2'b00 || timeout_pulse !== 1'b0 || s_valid !== 1'b1) begin errors++; $display("FAIL wdog c%0d ready/pulse/s_valid got=%b/%b/%b exp=00/0/1", c, m_ready, timeout_pulse, s_valid); end
            end else begin
                checks++; if (m_ready !== 2'b01 || timeout_pulse !== 1'b1) begin errors++; $display("FAIL wdog fire ready/pulse got=%b/%b exp=01/1", m_ready, timeout_pulse); end
                checks++; if (m_rdata !== 32'h0 || s_valid !== 1'b0) begin errors++; $display("FAIL wdog fire rdata/s_valid got=%h/%b exp=0/0", m_rdata, s_valid); end
            end
            tick();
        end
        m_valid = 2'b10;
        s_ready = 1'b1;
        #2;
        checks++; if (m_ready !== 2'b10 || s_address !== 32'h300 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL wdog handover ready/addr/pulse got=%b/%h/%b exp=10/00000300/0", m_ready, s_address, timeout_pulse); end
        checks++; if (m_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL wdog handover m_rdata got=%h exp=5555aaaa", m_rdata); end
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        m_valid = 2'b10;
        m_address[1] = 32'h0000_0044;
        tick();
        #2;
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rstmid busy s_valid got=%b exp=1", s_valid); end
        reset = 1'b1;
        s_ready = 1'b1;
        #1;
        checks++; if (s_valid !== 1'b0 || m_ready !== 2'b00 || s_address !== 32'h0) begin errors++; $display("FAIL rstmid async valid/ready/addr got=%b/%b/%h exp=0/00/0", s_valid, m_ready, s_address); end
        tick();
        reset = 1'b0;
        s_ready = 1'b0;
        m_valid = 2'b11;
        tick();
        s_ready = 1'b1;
        #2;
        checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL rstmid first grant m_ready got=%b exp=01", m_ready); end
        tick();
        m_valid = 2'b10;
        #2;
        checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL rstmid second grant m_ready got=%b exp=10", m_ready); end
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        tick();
    endtask

    task automatic test_irq;
        s_irq = 1'b1;
        #1;
        checks++; if (m_irq !== 1'b1) begin errors++; $display("FAIL irq idle high got=%b exp=1", m_irq); end
        s_irq = 1'b0;
        #1;
        checks++; if (m_irq !== 1'b0) begin errors++; $display("FAIL irq idle low got=%b exp=0", m_irq); end
        m_valid = 2'b10;
        tick();
        s_irq = 1'b1;
        #1;
        checks++; if (m_irq !== 1'b1 || s_valid !== 1'b1) begin errors++; $display("FAIL irq busy high irq/s_valid got=%b/%b exp=1/1", m_irq, s_valid); end
        s_irq = 1'b0;
        #1;
        checks++; if (m_irq !== 1'b0) begin errors++; $display("FAIL irq busy low got=%b exp=0", m_irq); end
        s_ready = 1'b1;
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        tick();
    endtask

    // model tracks who owns the slave and how long it has waited, nothing more
    task automatic test_random;
        int owner, waited, n;
        bit last, to, done;
        bit pend [2];
        logic [1:0] e_ready;
        logic e_valid;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0] e_strb;
        do_reset();
        tick();
        owner = -1; waited = 0; last = 1'b1; pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    m_address[i] = $urandom;
                    m_wdata[i] = $urandom;
                    m_wstrobe[i] = 4'($urandom_range(0, 15));
                end
                m_valid[i] = pend[i];
            end
            s_ready = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            s_irq = 1'($urandom_range(0, 1));
            #2;
            n = (owner < 0) ? 0 : owner;
            to = (owner >= 0) && (waited == TO) && !s_ready;
            done = (owner >= 0) && (s_ready || to);
            e_ready = done ? 2'(1 << n) : 2'b00;
            e_valid = (owner >= 0) && m_valid[n] && !to;
            e_addr = (owner >= 0) ? m_address[n] : 32'h0;
            e_wdata = (owner >= 0) ? m_wdata[n] : 32'h0;
            e_strb = (owner >= 0) ? m_wstrobe[n] : 4'h0;
            e_rdata = ((owner >= 0) && !to) ? s_rdata : 32'h0;
            checks++; if (m_ready !== e_ready) begin errors++; $display("FAIL rnd%0d m_ready got=%b exp=%b", cyc, m_ready, e_ready); end
            checks++; if (s_valid !== e_valid || timeout_pulse !== to) begin errors++; $display("FAIL rnd%0d s_valid/pulse got=%b/%b exp=%b/%b", cyc, s_valid, timeout_pulse, e_valid, to); end
            checks++; if (s_address !== e_addr || s_wdata !== e_wdata || s_wstrobe !== e_strb) begin errors++; $display("FAIL rnd%0d s_bus got=%h/%h/%h exp=%h/%h/%h", cyc, s_address, s_wdata, s_wstrobe, e_addr, e_wdata, e_strb); end
            checks++; if (m_rdata !== e_rdata || m_irq !== s_irq) begin errors++; $display("FAIL rnd%0d rdata/irq got=%h/%b exp=%h/%b", cyc, m_rdata, m_irq, e_rdata, s_irq); end
            if (owner < 0) begin
                if (m_valid == 2'b11) owner = last ? 0 : 1;
                else if (m_valid[0]) owner = 0;
                else if (m_valid[1]) owner = 1;
                waited = 0;
            end else if (done) begin
                last = owner[0];
                pend[owner] = 1'b0;
                if (m_valid[1 - owner]) begin
                    owner = 1 - owner;
                    waited = 0;
                end else owner = -1;
            end else waited++;
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_write();
        test_watchdog();
        test_reset_mid();
        test_irq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
